wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing a single slave port.
// Define WB_ARBITER_TIMEOUT_EN to add forced termination of stalled transactions.
module wb_arbiter #(
  parameter int AddrW         = 4,
  parameter int DataW         = 8,
  parameter int TimeoutCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             m0_wb_we_i,
  input  logic             m0_wb_stb_i,
  input  logic [AddrW-1:0] m0_wb_adr_i,
  input  logic [DataW-1:0] m0_wb_dat_i,
  output logic [DataW-1:0] m0_wb_dat_o,
  output logic             m0_wb_ack_o,
  input  logic             m1_wb_we_i,
  input  logic             m1_wb_stb_i,
  input  logic [AddrW-1:0] m1_wb_adr_i,
  input  logic [DataW-1:0] m1_wb_dat_i,
  output logic [DataW-1:0] m1_wb_dat_o,
  output logic             m1_wb_ack_o,
  output logic             s_wb_we_o,
  output logic             s_wb_stb_o,
  output logic [AddrW-1:0] s_wb_adr_o,
  output logic [DataW-1:0] s_wb_dat_o,
  input  logic [DataW-1:0] s_wb_dat_i,
  input  logic             s_wb_ack_i,
  output logic             grant_o,
  output logic             timeout_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state;
  logic             grant;
  logic             last;
  logic             busy;
  logic             leave;
  logic             fire_to;
  logic             sel_stb;
  logic             sel_we;
  logic [AddrW-1:0] sel_adr;
  logic [DataW-1:0] sel_dat;
  logic [DataW-1:0] ret_dat;

  if (TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_bad_timeout
    $error("wb_arbiter: TimeoutCycles must be within 2..255");
  end

  // Request fields of the currently granted master
  always_comb begin
    if (grant) begin
      sel_stb = m1_wb_stb_i;
      sel_we  = m1_wb_we_i;
      sel_adr = m1_wb_adr_i;
      sel_dat = m1_wb_dat_i;
    end else begin
      sel_stb = m0_wb_stb_i;
      sel_we  = m0_wb_we_i;
      sel_adr = m0_wb_adr_i;
      sel_dat = m0_wb_dat_i;
    end
  end

  assign busy = (state == BUSY);

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] LastCount = 8'(TimeoutCycles - 1);
  logic [7:0] to_cnt;

  // A slave ack in the final counted cycle wins over the forced termination
  assign fire_to = busy && sel_stb && !s_wb_ack_i && (to_cnt == LastCount);

  // Counts BUSY cycles; cleared whenever the transaction ends or the FSM is idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt <= 8'd0;
    end else if (busy && !leave) begin
      to_cnt <= to_cnt + 8'd1;
    end else begin
      to_cnt <= 8'd0;
    end
  end
`else
  assign fire_to = 1'b0;
`endif

  assign leave     = busy && (s_wb_ack_i || !sel_stb || fire_to);
  assign ret_dat   = fire_to ? {DataW{1'b1}} : s_wb_dat_i;
  assign timeout_o = fire_to;
  assign grant_o   = grant;

  // Combinational routing between the granted master and the slave
  always_comb begin
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_dat_o = '0;
    if (busy) begin
      s_wb_stb_o = sel_stb && !fire_to;
      s_wb_we_o  = sel_we;
      s_wb_adr_o = sel_adr;
      s_wb_dat_o = sel_dat;
      if (grant) begin
        m1_wb_ack_o = s_wb_ack_i || fire_to;
        m1_wb_dat_o = ret_dat;
      end else begin
        m0_wb_ack_o = s_wb_ack_i || fire_to;
        m0_wb_dat_o = ret_dat;
      end
    end else begin
      s_wb_stb_o = 1'b0;
    end
  end

  // Arbitration FSM: round-robin grant in IDLE, hold until ack/drop/timeout in BUSY
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_wb_stb_i || m1_wb_stb_i) begin
            state <= BUSY;
            grant <= (m0_wb_stb_i && m1_wb_stb_i) ? ~last : m1_wb_stb_i;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (leave) begin
            state <= IDLE;
            last  <= grant;
          end else begin
            state <= BUSY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a transaction-level model.
// Timeout expectations follow WB_ARBITER_TIMEOUT_EN, matching the RTL build.
module tb_wb_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 16;
`ifdef WB_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic m0_we = 1'b0, m0_stb = 1'b0, m1_we = 1'b0, m1_stb = 1'b0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_dat = '0, m1_dat = '0, s_rdat = '0;
  logic s_ack = 1'b0;
  logic [DW-1:0] m0_rdat, m1_rdat, s_wdat;
  logic m0_ack, m1_ack, s_we, s_stb, grant, tmo;
  logic [AW-1:0] s_adr;

  int n_checks = 0;
  int n_fail = 0;
  int owner = -1;
  int last = 1;
  int gr = 0;
  int age = 0;
  int obs_to = 0;
  logic e_ack0 = 1'b0, e_ack1 = 1'b0;

  wb_arbiter #(.AddrW(AW), .DataW(DW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_wb_we_i(m0_we), .m0_wb_stb_i(m0_stb), .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat),
    .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack),
    .m1_wb_we_i(m1_we), .m1_wb_stb_i(m1_stb), .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat),
    .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack),
    .s_wb_we_o(s_we), .s_wb_stb_o(s_stb), .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack),
    .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sbus"}, 32'({s_stb, s_we, s_adr, s_wdat}), 32'd0);
    check({tag, "_m0"}, 32'({m0_ack, m0_rdat}), 32'd0);
    check({tag, "_m1"}, 32'({m1_ack, m1_rdat}), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_timeout"}, 32'(tmo), 32'd0);
  endtask

  // One bus cycle: drive, compare against the model, then advance the model at the edge
  task automatic cycle(input logic st0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic st1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic ack, input logic [DW-1:0] sd);
    logic [13:0] e_bus;
    logic [8:0] e_m0, e_m1;
    logic ost;
    logic fire;
    @(negedge clk);
    m0_stb = st0; m0_we = we0; m0_adr = a0; m0_dat = d0;
    m1_stb = st1; m1_we = we1; m1_adr = a1; m1_dat = d1;
    s_ack = ack; s_rdat = sd;
    #1;
    e_bus = '0; e_m0 = '0; e_m1 = '0; fire = 1'b0; ost = 1'b0;
    if (owner >= 0) begin
      ost = (owner == 1) ? st1 : st0;
      fire = TO_EN && ost && !ack && (age == TO - 1);
      if (owner == 1) begin
        e_bus = {ost && !fire, we1, a1, d1};
        e_m1 = {ack || fire, fire ? 8'hFF : sd};
      end else begin
        e_bus = {ost && !fire, we0, a0, d0};
        e_m0 = {ack || fire, fire ? 8'hFF : sd};
      end
    end
    check("sbus", 32'({s_stb, s_we, s_adr, s_wdat}), 32'(e_bus));
    check("m0_ret", 32'({m0_ack, m0_rdat}), 32'(e_m0));
    check("m1_ret", 32'({m1_ack, m1_rdat}), 32'(e_m1));
    check("grant", 32'(grant), 32'(gr));
    check("timeout", 32'(tmo), 32'(fire));
    if (tmo) obs_to++;
    e_ack0 = e_m0[8];
    e_ack1 = e_m1[8];
    @(posedge clk);
    if (owner < 0) begin
      if (st0 || st1) begin
        owner = (st0 && st1) ? 1 - last : (st1 ? 1 : 0);
        gr = owner;
        age = 0;
      end
    end else if (ack || !ost || fire) begin
      last = owner;
      owner = -1;
      age = 0;
    end else begin
      age++;
    end
  endtask

  task automatic do_reset(input logic hold_ack);
    @(negedge clk);
    s_ack = hold_ack;
    rst_ni = 1'b0;
    #1;
    check_zero("in_reset");
    owner = -1; last = 1; gr = 0; age = 0;
    @(negedge clk);
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    rst_ni = 1'b1;
    #1;
    check_zero("after_reset");
  endtask

  initial begin
    logic r0, r1;
    logic [31:0] rnd;
    int to_hold;
    #2 rst_ni = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    #1 check_zero("post_reset");

    // single m0 write, slave acks one cycle after strobe
    cycle(1'b1, 1'b1, 4'd2, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 4'd2, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 4'd2, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);

    // fresh reset, then simultaneous requests: m0, then m1, then a repeated tie to m0
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 4'd1, 8'h11, 1'b1, 1'b0, 4'd9, 8'h99, 1'b0, 8'h00);
    #1 check("tie_first_m0", 32'(grant), 32'd0);
    cycle(1'b1, 1'b0, 4'd1, 8'h11, 1'b1, 1'b0, 4'd9, 8'h99, 1'b1, 8'h12);
    cycle(1'b0, 1'b0, 4'd1, 8'h11, 1'b1, 1'b0, 4'd9, 8'h99, 1'b0, 8'h00);
    #1 check("tie_then_m1", 32'(grant), 32'd1);
    cycle(1'b0, 1'b0, 4'd1, 8'h11, 1'b1, 1'b0, 4'd9, 8'h99, 1'b1, 8'h34);
    cycle(1'b1, 1'b0, 4'd3, 8'h22, 1'b1, 1'b0, 4'd7, 8'h77, 1'b0, 8'h00);
    #1 check("tie_again_m0", 32'(grant), 32'd0);
    cycle(1'b1, 1'b0, 4'd3, 8'h22, 1'b1, 1'b0, 4'd7, 8'h77, 1'b1, 8'h56);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd7, 8'h77, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd7, 8'h77, 1'b1, 8'h3C);

    // m1 read returning 8'h3C
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 8'h3C);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);

    // granted m0 drops its strobe; pending m1 is served next
    cycle(1'b1, 1'b1, 4'd4, 8'h44, 1'b1, 1'b1, 4'd6, 8'h66, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 4'd4, 8'h44, 1'b1, 1'b1, 4'd6, 8'h66, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd6, 8'h66, 1'b0, 8'h00);
    #1 check("drop_then_m1", 32'(grant), 32'd1);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd6, 8'h66, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);

    // slave never acks: forced termination when enabled, indefinite wait otherwise
    obs_to = 0;
    to_hold = 1 + TO + 8;
    for (int i = 0; i < to_hold; i++)
      cycle(1'b1, 1'b0, 4'd8, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h5A);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    check("timeout_pulses", 32'(obs_to), TO_EN ? 32'd1 : 32'd0);

    // reset in the middle of a transaction, slave ack held high throughout
    cycle(1'b1, 1'b1, 4'd2, 8'hC3, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    do_reset(1'b1);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd1, 8'h0F, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd1, 8'h0F, 1'b1, 8'h00);

    // randomised traffic: masters hold stb until acked, occasionally abandon
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (r0 && e_ack0) r0 = 1'b0;
      else if (!r0) r0 = ($urandom_range(1, 0) == 1);
      else if ($urandom_range(15, 0) == 0) r0 = 1'b0;
      if (r1 && e_ack1) r1 = 1'b0;
      else if (!r1) r1 = ($urandom_range(1, 0) == 1);
      else if ($urandom_range(15, 0) == 0) r1 = 1'b0;
      rnd = $urandom;
      cycle(r0, rnd[0], rnd[4:1], rnd[12:5], r1, rnd[13], rnd[17:14], rnd[25:18],
            ($urandom_range(4, 0) == 0), rnd[31:24]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
